// File: rtl/riscv_test_pkg.sv
// Shared types and constants for the rv32ui pass/fail monitor.
package riscv_test_pkg;

  typedef enum logic [2:0] {
    ST_RUN,
    ST_SETTLE,
    ST_PASS,
    ST_FAIL,
    ST_TIMEOUT
  } state_t;

  localparam logic [4:0] REG_TESTNUM = 5'd3;
  localparam logic [4:0] REG_FLAG_A  = 5'd26;
  localparam logic [4:0] REG_FLAG_B  = 5'd27;

  // Verdict states never leave until reset.
  function automatic logic is_terminal(input state_t s);
    return (s == ST_PASS) || (s == ST_FAIL) || (s == ST_TIMEOUT);
  endfunction

endpackage

// File: rtl/riscv_test_monitor_if.sv
// Register-file write-back port as seen by the monitor (core drives, monitor snoops).
interface riscv_test_monitor_if;
  logic        wb_en;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;

  modport master (output wb_en, output wb_addr, output wb_data);
  modport slave  (input  wb_en, input  wb_addr, input  wb_data);
endinterface

// File: rtl/riscv_test_monitor_sat_counter.sv
// Saturating up-counter: counts while en and not freeze, sticks at all-ones.
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic         freeze,
  output logic [W-1:0] cnt
);

  // Count, holding at the top value instead of wrapping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                               cnt <= '0;
    else if (en && !freeze && (cnt != '1))    cnt <= cnt + W'(1);
  end

endmodule

// File: rtl/riscv_test_monitor.sv
// Pass/fail monitor for rv32ui-p programs. Snoops write-back for x3/x26/x27,
// settles after the first completion flag, then latches a sticky verdict.
// Optional: define TEST_MON_HALT_EN to add a halt_req output that rises with done.
module riscv_test_monitor
  import riscv_test_pkg::*;
#(
  parameter int SETTLE_CYCLES  = 10,
  parameter int TIMEOUT_CYCLES = 100000,
  parameter int CNT_W          = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  riscv_test_monitor_if.slave  wb,
  output logic                 done,
  output logic                 pass,
  output logic                 fail,
  output logic                 timeout,
  output logic [31:0]          test_num,
  output logic [CNT_W-1:0]     cycle_cnt
`ifdef TEST_MON_HALT_EN
  ,
  output logic                 halt_req
`endif
);

  localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

  state_t        state, state_nxt;
  logic [SW-1:0] settle_cnt, settle_nxt;
  logic [31:0]   flag_a, flag_b;
  logic [31:0]   test_num_nxt, flag_a_nxt, flag_b_nxt;
  logic          live;

  // Shadows only track the core while no verdict has been reached.
  always_comb begin
    live         = (state == ST_RUN) || (state == ST_SETTLE);
    test_num_nxt = test_num;
    flag_a_nxt   = flag_a;
    flag_b_nxt   = flag_b;
    if (live && wb.wb_en) begin
      if (wb.wb_addr == REG_TESTNUM) test_num_nxt = wb.wb_data;
      if (wb.wb_addr == REG_FLAG_A)  flag_a_nxt   = wb.wb_data;
      if (wb.wb_addr == REG_FLAG_B)  flag_b_nxt   = wb.wb_data;
    end
  end

  // Shadow registers; test_num doubles as the x3 shadow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      test_num <= '0;
      flag_a   <= '0;
      flag_b   <= '0;
    end else begin
      test_num <= test_num_nxt;
      flag_a   <= flag_a_nxt;
      flag_b   <= flag_b_nxt;
    end
  end

  // Next state: RUN looks at the registered flags (one edge after the write);
  // the verdict itself sees a flag write landing on the same edge.
  always_comb begin
    state_nxt  = state;
    settle_nxt = settle_cnt;
    case (state)
      ST_RUN: begin
        if ((flag_a == 32'd1) || (flag_b == 32'd1)) begin
          state_nxt  = ST_SETTLE;
          settle_nxt = SW'(SETTLE_CYCLES - 1);
        end else if (cycle_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          state_nxt  = ST_TIMEOUT;
        end
      end
      ST_SETTLE: begin
        if (settle_cnt == '0)
          state_nxt = ((flag_a_nxt == 32'd1) && (flag_b_nxt == 32'd1)) ? ST_PASS : ST_FAIL;
        else
          settle_nxt = settle_cnt - SW'(1);
      end
      default: state_nxt = state;
    endcase
  end

  // State, settle countdown and registered status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_RUN;
      settle_cnt <= '0;
      done       <= 1'b0;
      pass       <= 1'b0;
      fail       <= 1'b0;
      timeout    <= 1'b0;
    end else begin
      state      <= state_nxt;
      settle_cnt <= settle_nxt;
      done       <= is_terminal(state_nxt);
      pass       <= (state_nxt == ST_PASS);
      fail       <= (state_nxt == ST_FAIL) || (state_nxt == ST_TIMEOUT);
      timeout    <= (state_nxt == ST_TIMEOUT);
    end
  end

  // The cycle count stops on the verdict edge so it reads the last live cycle.
  sat_counter #(.W(CNT_W)) u_cycle_cnt (
    .clk    (clk),
    .rst_n  (rst_n),
    .en     (!is_terminal(state_nxt)),
    .freeze (is_terminal(state)),
    .cnt    (cycle_cnt)
  );

`ifdef TEST_MON_HALT_EN
  // Stall request to the core, rising together with done.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) halt_req <= 1'b0;
    else        halt_req <= is_terminal(state_nxt);
  end
`endif

endmodule

// File: tb/tb_riscv_test_monitor.sv
// Directed table-driven bench for riscv_test_monitor (SETTLE=10, TIMEOUT=50).
module tb_riscv_test_monitor;
  import riscv_test_pkg::*;

  localparam int SETTLE  = 10;
  localparam int TIMEOUT = 50;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        done, pass, fail, timeout;
  logic [31:0] test_num, cycle_cnt;
`ifdef TEST_MON_HALT_EN
  logic        halt_req;
`endif

  riscv_test_monitor_if wbi();

  riscv_test_monitor #(
    .SETTLE_CYCLES(SETTLE), .TIMEOUT_CYCLES(TIMEOUT), .CNT_W(32)
  ) dut (
    .clk(clk), .rst_n(rst_n), .wb(wbi),
    .done(done), .pass(pass), .fail(fail), .timeout(timeout),
    .test_num(test_num), .cycle_cnt(cycle_cnt)
`ifdef TEST_MON_HALT_EN
    , .halt_req(halt_req)
`endif
  );

  always #5 clk = ~clk;

  // one write-back event: lands on edge t (t==0 means unused slot)
  typedef struct packed {
    logic [7:0]  t;
    logic        en;
    logic [4:0]  a;
    logic [31:0] d;
  } wr_t;

  typedef struct {
    wr_t [3:0]   w;
    int          v_edge;   // edge on which done must rise
    logic [3:0]  flags;    // {done,pass,fail,timeout} after verdict
    logic [31:0] tn;
    logic [31:0] cc;
  } vec_t;

  int   n_vec = 0;
  int   n_bad = 0;
  vec_t vecs[10];

  function automatic wr_t mk(input int t, input logic en, input int a, input logic [31:0] d);
    wr_t r;
    r.t = 8'(t); r.en = en; r.a = 5'(a); r.d = d;
    return r;
  endfunction

  function automatic vec_t mkv(input wr_t w0, w1, w2, w3, input int ve,
                               input logic [3:0] f, input logic [31:0] tn, cc);
    vec_t v;
    v.w[0] = w0; v.w[1] = w1; v.w[2] = w2; v.w[3] = w3;
    v.v_edge = ve; v.flags = f; v.tn = tn; v.cc = cc;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    wbi.wb_en = 1'b0; wbi.wb_addr = '0; wbi.wb_data = '0;
    #1;
    chk("reset_flags", {60'd0, done, pass, fail, timeout}, 64'd0);
    chk("reset_tn_cc", {test_num, cycle_cnt}, 64'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Drive the write scheduled for edge e (if any); called on the negedge before it.
  task automatic drive(input vec_t v, input int e);
    wbi.wb_en = 1'b0; wbi.wb_addr = '0; wbi.wb_data = '0;
    for (int k = 0; k < 4; k++)
      if (v.w[k].t != 8'd0 && int'(v.w[k].t) == e) begin
        wbi.wb_en = v.w[k].en; wbi.wb_addr = v.w[k].a; wbi.wb_data = v.w[k].d;
      end
  endtask

  task automatic run_vec(input vec_t v, input int vi);
    string nm;
    do_reset();
    for (int e = 1; e <= v.v_edge + 2; e++) begin
      drive(v, e);
      // after the verdict, a late x3 write must not disturb the frozen outputs
      if (e == v.v_edge + 1) begin
        wbi.wb_en = 1'b1; wbi.wb_addr = 5'd3; wbi.wb_data = 32'hDEAD_BEEF;
      end
      @(posedge clk);
      #1;
      if (e < v.v_edge) begin
        nm = $sformatf("v%0d_pre_e%0d", vi, e);
        chk({nm, "_flags"}, {60'd0, done, pass, fail, timeout}, 64'd0);
        chk({nm, "_cc"}, {32'd0, cycle_cnt}, 64'(e));
      end else begin
        nm = $sformatf("v%0d_post_e%0d", vi, e);
        chk({nm, "_flags"}, {60'd0, done, pass, fail, timeout}, {60'd0, v.flags});
        chk({nm, "_tn"}, {32'd0, test_num}, {32'd0, v.tn});
        chk({nm, "_cc"}, {32'd0, cycle_cnt}, {32'd0, v.cc});
`ifdef TEST_MON_HALT_EN
        chk({nm, "_halt"}, {63'd0, halt_req}, 64'd1);
`endif
      end
`ifdef TEST_MON_HALT_EN
      if (e < v.v_edge) chk({nm, "_halt"}, {63'd0, halt_req}, 64'd0);
`endif
      @(negedge clk);
    end
    wbi.wb_en = 1'b0;
  endtask

  initial begin
    wr_t  nw;
    vec_t hv;
    nw = '0;
    wbi.wb_en = 1'b0; wbi.wb_addr = '0; wbi.wb_data = '0;

    // {done,pass,fail,timeout}: pass=4'b1100, fail=4'b1010, timeout=4'b1011
    vecs[0] = mkv(mk(10,1,3,5), mk(40,1,26,1), mk(42,1,27,1), nw, 51, 4'b1100, 32'd5, 32'd50);
    vecs[1] = mkv(mk(5,1,3,7), mk(20,1,27,1), nw, nw, 31, 4'b1010, 32'd7, 32'd30);
    vecs[2] = mkv(nw, nw, nw, nw, 50, 4'b1011, 32'd0, 32'd49);
    // flag seen in the same cycle the watchdog would fire: flag wins
    vecs[3] = mkv(mk(3,1,3,9), mk(49,1,26,1), nw, nw, 60, 4'b1010, 32'd9, 32'd59);
    // flag written on the timeout edge is too late
    vecs[4] = mkv(mk(1,1,3,2), mk(50,1,26,1), nw, nw, 50, 4'b1011, 32'd2, 32'd49);
    vecs[5] = mkv(mk(1,1,3,32'h1234), mk(30,1,27,1), mk(40,1,26,1), nw, 41, 4'b1100, 32'h1234, 32'd40);
    // second flag lands on the verdict edge itself
    vecs[6] = mkv(mk(2,1,3,32'hA), mk(10,1,26,1), mk(21,1,27,1), nw, 21, 4'b1100, 32'hA, 32'd20);
    // flag value 2 is not a completion flag; 1 elsewhere still triggers settle
    vecs[7] = mkv(mk(1,1,3,32'hFFFF_FFFF), mk(10,1,26,2), mk(15,1,27,1), nw, 26, 4'b1010, 32'hFFFF_FFFF, 32'd25);
    // writes to x0, x25, x28 are ignored
    vecs[8] = mkv(mk(1,1,3,4), mk(2,1,0,1), mk(3,1,25,1), mk(4,1,28,1), 50, 4'b1011, 32'd4, 32'd49);
    // wb_en low ignored; flag cleared during settle forces fail
    vecs[9] = mkv(mk(1,1,3,4), mk(2,0,3,32'h55), mk(20,1,26,1), mk(25,1,26,0), 31, 4'b1010, 32'd4, 32'd30);

    for (int i = 0; i < 10; i++) run_vec(vecs[i], i);

    // Reset pulse in the middle of SETTLE clears everything asynchronously.
    hv = mkv(mk(2,1,3,3), mk(5,1,26,1), nw, nw, 0, 4'b0, 32'd0, 32'd0);
    do_reset();
    for (int e = 1; e <= 8; e++) begin
      drive(hv, e);
      @(posedge clk);
      @(negedge clk);
    end
    wbi.wb_en = 1'b0;
    chk("mid_settle_cc", {32'd0, cycle_cnt}, 64'd8);
    rst_n = 1'b0;
    #1;
    chk("abort_flags", {60'd0, done, pass, fail, timeout}, 64'd0);
    chk("abort_tn_cc", {test_num, cycle_cnt}, 64'd0);
`ifdef TEST_MON_HALT_EN
    chk("abort_halt", {63'd0, halt_req}, 64'd0);
`endif
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    // settle from the aborted run must not leak: rerun the passing sequence
    run_vec(vecs[0], 100);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/riscv_test_monitor.md
Name: riscv_test_monitor

Overview:
- Synthesizable pass/fail monitor for rv32ui-p compliance programs; sits downstream of the CPU core and snoops the register-file write-back port.
- Shadows x3 (test number), x26 and x27 (completion flags). Once a flag is written to 1 it waits a settle window, then declares pass or fail. A watchdog declares timeout if no flag arrives.
- Replaces hierarchical peeks in simulation and drives LEDs/status bits on FPGA.

Parameters:
- SETTLE_CYCLES, 10, cycles between first flag==1 and the verdict (200 ns at a 20 ns clock).
- TIMEOUT_CYCLES, 100000, cycles in RUN before a timeout is declared.
- CNT_W, 32, width of the cycle counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- wb_en  in  1  register-file write enable this cycle.
- wb_addr  in  5  destination register index.
- wb_data  in  32  write data.
- done  out  1  verdict reached; sticky until reset.
- pass  out  1  x26==1 and x27==1 at verdict; sticky.
- fail  out  1  verdict reached without pass (includes timeout); sticky.
- timeout  out  1  watchdog expired; sticky.
- test_num  out  32  shadow of x3, frozen at verdict.
- cycle_cnt  out  CNT_W  cycles since reset release, frozen at verdict, saturating.

Behaviour:
- Reset (async, rst_n low):
  - State goes to RUN.
  - All shadows, counters and outputs are cleared to 0.
  - Asserting rst_n mid-test or after a verdict aborts the test and clears everything immediately.
- Shadow update: on the clk edge with wb_en=1 and wb_addr in {3, 26, 27}, the matching shadow takes wb_data.
  - wb_addr=0 is ignored.
  - Other addresses are ignored.
- FSM states:
  - RUN:
    - cycle_cnt increments each cycle, saturating at all-ones.
    - If the post-update shadow26==1 or shadow27==1, go to SETTLE and load settle_cnt=SETTLE_CYCLES-1. The write itself counts, so the flag write cycle triggers SETTLE on the next edge.
    - Else if cycle_cnt == TIMEOUT_CYCLES-1, go to TIMEOUT.
    - If the flag and timeout conditions occur in the same cycle, the flag wins.
  - SETTLE:
    - Shadows keep updating; cycle_cnt keeps counting; settle_cnt decrements.
    - When settle_cnt==0, evaluate: shadow26==1 and shadow27==1 gives PASS, otherwise FAIL.
    - Evaluation uses shadows including a write on that same edge.
    - SETTLE_CYCLES=1 means the verdict comes on the next edge.
  - PASS: done=1, pass=1. Terminal; shadow updates are frozen.
  - FAIL: done=1, fail=1. Terminal.
  - TIMEOUT: done=1, fail=1, timeout=1. Terminal.
- All outputs are registered. done rises exactly SETTLE_CYCLES+1 edges after the edge that wrote the first flag.
- A flag later overwritten to 0 before the verdict gives FAIL; the FSM does not return to RUN.
- Exactly one of pass/fail is 1 whenever done=1. Both are 0 when done=0.

Optional Feature:
- Macro: TEST_MON_HALT_EN.
- Defined:
  - Adds output port halt_req (1 bit), registered, reset 0.
  - halt_req asserts on the same edge that done rises and stays high until reset.
  - The core top ties it to the PC-hold/stall input so the CPU freezes after the verdict.
- Not defined: the port does not exist and the CPU runs freely after the verdict.

Decomposition:
- Shared package `riscv_test_pkg`:
  - FSM state encoding (ST_RUN, ST_SETTLE, ST_PASS, ST_FAIL, ST_TIMEOUT).
  - Register index constants REG_TESTNUM=3, REG_FLAG_A=26, REG_FLAG_B=27.
- One natural sub-module: `sat_counter` (parameterised-width saturating up-counter with enable and freeze), used for cycle_cnt.
- The settle countdown stays inline.

Test Plan:
- Write x3=5, then x26=1 at cycle 40, then x27=1 at cycle 42, SETTLE_CYCLES=10 -> done=1, pass=1, fail=0 at cycle 51; test_num=5.
- Write x3=7, then x27=1 only, x26 stays 0 -> fail=1, pass=0, timeout=0 at SETTLE_CYCLES+1 cycles after the write; test_num=7.
- No flag writes, TIMEOUT_CYCLES=50 -> timeout=1, fail=1 on edge 50; cycle_cnt=49 frozen.
- Write wb_addr=0 and wb_addr=25 with data 1; x26=1 written then x26=0 during SETTLE -> no shadow change from the index-0/25 writes; final fail=1.
- Drop rst_n for 1 cycle during SETTLE, then rerun the passing sequence -> all outputs 0 during reset, then pass=1. With TEST_MON_HALT_EN defined, halt_req rises on the same edge as done.
